// File: rtl/ext_fifo_pkg.sv
// Shared types and constants for the GEM external-FIFO TX packet buffer.
package ext_fifo_pkg;

    localparam int EXT_FIFO_DATA_W       = 8;
    localparam int EXT_FIFO_ENTRY_W      = EXT_FIFO_DATA_W + 2;
    localparam int EXT_FIFO_DEPTH_DEF    = 2048;
    localparam int EXT_FIFO_MAX_PKTS_DEF = 16;

    // One RAM word: error flag and frame-end marker travel with each byte.
    typedef struct packed {
        logic                       tuser;
        logic                       tlast;
        logic [EXT_FIFO_DATA_W-1:0] tdata;
    } ext_fifo_entry_t;

    // What happens to the frame whose tlast beat is accepted this cycle.
    typedef enum logic [1:0] {
        END_COMMIT   = 2'd0,
        END_OVERFLOW = 2'd1,
        END_ERRDROP  = 2'd2
    } ext_fifo_end_e;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ext_fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ext_fifo_tx_pkt_buf_if.sv
// 8-bit AXI-Stream link used on both sides of the TX packet buffer.
interface ext_fifo_tx_pkt_buf_if;
    import ext_fifo_pkg::*;

    logic [EXT_FIFO_DATA_W-1:0] tdata;
    logic                       tvalid;
    logic                       tlast;
    logic                       tuser;
    logic                       tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/ext_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Only the read register is reset; the array itself is not.
module ext_fifo_sdp_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the byte entry at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: the register holds its value until the next read is issued.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ext_fifo_tx_pkt_buf.sv
// Store-and-forward packet buffer for the GEM external-FIFO TX path.
// A frame is released downstream only once it has been fully stored.
// Frames that overrun the RAM or exceed MAX_PKTS are discarded whole.
// Optional build macro EXT_FIFO_TX_DROP_ERR_EN: frames ending with tuser=1
// are discarded (drop_o pulses) and m_axis.tuser is held 0.
module ext_fifo_tx_pkt_buf
    import ext_fifo_pkg::*;
#(
    parameter int DEPTH    = EXT_FIFO_DEPTH_DEF,
    parameter int MAX_PKTS = EXT_FIFO_MAX_PKTS_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    ext_fifo_tx_pkt_buf_if.slave      s_axis,
    ext_fifo_tx_pkt_buf_if.master     m_axis,
    output logic [$clog2(MAX_PKTS):0] pkt_count_o,
    output logic                      overflow_o,
    output logic                      drop_o
);

    localparam int PW = ext_fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;

    localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
    localparam logic [CW-1:0] MAX_PKTS_P = CW'(MAX_PKTS);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   commit_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   used;
    logic [CW-1:0]   pkt_cnt;
    logic            overrun;
    logic            s_rdy;
    logic            m_vld;

    logic            accept;
    logic            full;
    logic            pkts_full;
    logic            wr_en;
    logic            end_beat;
    logic            err_flag;
    logic            commit;
    logic            rd_en;
    logic            last_xfer;
    ext_fifo_end_e   end_kind;
    ext_fifo_entry_t wr_entry;
    ext_fifo_entry_t rd_entry;

`ifdef EXT_FIFO_TX_DROP_ERR_EN
    logic            drop_q;

    assign err_flag = s_axis.tuser;
    assign drop_o   = drop_q;
`else
    assign err_flag = 1'b0;
    assign drop_o   = 1'b0;
`endif

    assign used        = wr_ptr - rd_ptr;
    assign full        = (used == DEPTH_P);
    assign pkts_full   = (pkt_cnt == MAX_PKTS_P);
    assign pkt_count_o = pkt_cnt;

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_vld;
    assign m_axis.tdata  = rd_entry.tdata;
    assign m_axis.tlast  = rd_entry.tlast;
    assign m_axis.tuser  = rd_entry.tuser;

    // Ingress decode: write gating and the fate of a frame ending this cycle.
    always_comb begin
        accept   = s_axis.tvalid & s_rdy;
        wr_en    = accept & ~full & ~overrun;
        end_beat = accept & s_axis.tlast;
        end_kind = END_COMMIT;
        if (overrun || full || pkts_full) begin
            end_kind = END_OVERFLOW;
        end else if (err_flag) begin
            end_kind = END_ERRDROP;
        end
        commit = end_beat && (end_kind == END_COMMIT);

        wr_entry.tdata = s_axis.tdata;
        wr_entry.tlast = s_axis.tlast;
`ifdef EXT_FIFO_TX_DROP_ERR_EN
        wr_entry.tuser = 1'b0;
`else
        wr_entry.tuser = s_axis.tuser & s_axis.tlast;
`endif
    end

    // Egress decode: the output register is refilled whenever it empties or
    // is consumed, so committed data streams without bubbles.
    always_comb begin
        rd_en     = (rd_ptr != commit_ptr) && (!m_vld || m_axis.tready);
        last_xfer = m_vld & m_axis.tready & rd_entry.tlast;
    end

    // Ingress state: write pointer, overrun mark, commit/rollback and pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_rdy      <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            overrun    <= 1'b0;
            overflow_o <= 1'b0;
`ifdef EXT_FIFO_TX_DROP_ERR_EN
            drop_q     <= 1'b0;
`endif
        end else begin
            s_rdy      <= 1'b1;
            overflow_o <= 1'b0;
`ifdef EXT_FIFO_TX_DROP_ERR_EN
            drop_q     <= 1'b0;
`endif
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (accept && full) begin
                overrun <= 1'b1;
            end
            // Frame end overrides the write increment and the overrun mark set
            // above; a commit always includes this beat's own write.
            if (end_beat) begin
                overrun <= 1'b0;
                case (end_kind)
                    END_COMMIT: begin
                        commit_ptr <= wr_ptr + PW'(1);
                    end
                    END_OVERFLOW: begin
                        wr_ptr     <= commit_ptr;
                        overflow_o <= 1'b1;
                    end
                    default: begin
                        wr_ptr     <= commit_ptr;
`ifdef EXT_FIFO_TX_DROP_ERR_EN
                        drop_q     <= 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    // Egress state: read pointer, output-register valid and committed frame count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr  <= '0;
            m_vld   <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
                m_vld  <= 1'b1;
            end else if (m_axis.tready) begin
                m_vld  <= 1'b0;
            end
            case ({commit, last_xfer})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    ext_fifo_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EXT_FIFO_ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_ext_fifo_tx_pkt_buf.sv
// Bench for ext_fifo_tx_pkt_buf (DEPTH=64, MAX_PKTS=4).
// A frame-level model holds the bytes of committed, not-yet-sent frames in a
// queue; every cycle the DUT outputs are compared against it, and directed
// literal checks pin latency, counts and pulse totals.
module tb_ext_fifo_tx_pkt_buf;

    typedef enum {OC_COMMIT, OC_OVF, OC_ERR} oc_e;
    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] pkt_count;
    logic       overflow;
    logic       drop;

    ext_fifo_tx_pkt_buf_if s_if ();
    ext_fifo_tx_pkt_buf_if m_if ();

    ext_fifo_tx_pkt_buf #(
        .DEPTH    (64),
        .MAX_PKTS (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .pkt_count_o (pkt_count),
        .overflow_o  (overflow),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    bit    chk_en = 1'b0;
    oc_e   cur_oc = OC_COMMIT;
    beat_t exp_q[$];
    beat_t cur_q[$];
    int    cnt_m = 0;
    bit    rdy_m = 1'b0;
    bit    ovf_exp = 1'b0;
    bit    drop_exp = 1'b0;
    int    n_out = 0;
    int    n_ovf = 0;
    int    n_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ingress frames are held until their tlast decides their fate;
    // committed frames join the expected egress queue.
    always @(posedge clk) begin
        ovf_exp  = 1'b0;
        drop_exp = 1'b0;
        if (!rstn) begin
            exp_q.delete();
            cur_q.delete();
            cnt_m = 0;
            rdy_m = 1'b0;
        end else begin
            if (m_if.tvalid && m_if.tready && exp_q.size() > 0) begin
                if (exp_q[0].l) cnt_m--;
                exp_q.delete(0);
                n_out++;
            end
            if (s_if.tvalid && rdy_m) begin
`ifdef EXT_FIFO_TX_DROP_ERR_EN
                cur_q.push_back('{s_if.tdata, s_if.tlast, 1'b0});
`else
                cur_q.push_back('{s_if.tdata, s_if.tlast, s_if.tlast & s_if.tuser});
`endif
                if (s_if.tlast) begin
                    case (cur_oc)
                        OC_COMMIT: begin
                            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                            cnt_m++;
                        end
                        OC_OVF:  ovf_exp  = 1'b1;
                        default: drop_exp = 1'b1;
                    endcase
                    cur_q.delete();
                end
            end
            rdy_m = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (overflow === 1'b1) n_ovf++;
        if (drop === 1'b1) n_drop++;
        if (chk_en) begin
            chk("pkt_count", 32'(pkt_count), 32'(cnt_m));
            chk("overflow_o", 32'(overflow), 32'(ovf_exp));
            chk("drop_o", 32'(drop), 32'(drop_exp));
            chk("s_tready", 32'(s_if.tready), 32'(rdy_m));
            if (m_if.tvalid) begin
                if (exp_q.size() == 0)
                    chk("m_tvalid_unexpected", 32'(m_if.tvalid), 32'd0);
                else
                    chk("m_beat", {21'd0, m_if.tuser, m_if.tlast, m_if.tdata},
                        {21'd0, exp_q[0].u, exp_q[0].l, exp_q[0].d});
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic last, input logic user);
        int t = 0;
        while (s_if.tready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("s_tready_timeout", 32'(s_if.tready), 32'd1);
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        s_if.tuser  = user;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic user, input oc_e oc);
        cur_oc = oc;
        for (int i = 0; i < len; i++) begin
            beat(8'(base + 8'(i)), i == len - 1, user && (i == len - 1));
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int cyc;
        int gaps;
        int o0;
        int v0;
        int d0;
        bit done;

        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 32'(s_if.tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_m_tuser", 32'(m_if.tuser), 32'd0);
        chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk_en = 1'b1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("s_tready_rise", 32'(s_if.tready), 32'd1);

        // 64-byte frame streaming out with egress ready
        send_frame(64, 8'h10, 1'b0, OC_COMMIT);
        chk("t1_cnt_commit", 32'(pkt_count), 32'd1);
        lat = 1;
        while (!m_if.tvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'd2);
        cyc = 0; gaps = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            cyc++;
            if (!m_if.tvalid) gaps++;
            if (m_if.tvalid && m_if.tlast) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("t1_burst_cycles", 32'(cyc), 32'd64);
        chk("t1_gaps", 32'(gaps), 32'd0);
        @(posedge clk); #1;
        chk("t1_cnt_sent", 32'(pkt_count), 32'd0);
        drain();

        // Three 1-byte frames held back, then released
        m_if.tready = 1'b0;
        v0 = n_out;
        send_frame(1, 8'hA1, 1'b0, OC_COMMIT);
        send_frame(1, 8'hA2, 1'b0, OC_COMMIT);
        send_frame(1, 8'hA3, 1'b0, OC_COMMIT);
        chk("t2_cnt3", 32'(pkt_count), 32'd3);
        m_if.tready = 1'b1;
        drain();
        chk("t2_out", 32'(n_out - v0), 32'd3);
        chk("t2_cnt0", 32'(pkt_count), 32'd0);

        // Exact-depth frame commits; following DEPTH+1 frame is dropped
        m_if.tready = 1'b0;
        v0 = n_out; o0 = n_ovf;
        send_frame(64, 8'h00, 1'b0, OC_COMMIT);
        send_frame(65, 8'h80, 1'b0, OC_OVF);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_ovf_pulses", 32'(n_ovf - o0), 32'd1);
        chk("t3_cnt", 32'(pkt_count), 32'd1);
        m_if.tready = 1'b1;
        drain();
        chk("t3_out", 32'(n_out - v0), 32'd64);

        // Packet-slot limit: fifth frame dropped
        m_if.tready = 1'b0;
        v0 = n_out; o0 = n_ovf;
        for (int f = 0; f < 5; f++) begin
            send_frame(2, 8'(8'h40 + 8'(f * 16)), 1'b0, (f == 4) ? OC_OVF : OC_COMMIT);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t4_ovf_pulses", 32'(n_ovf - o0), 32'd1);
        chk("t4_cnt", 32'(pkt_count), 32'd4);
        m_if.tready = 1'b1;
        drain();
        chk("t4_out", 32'(n_out - v0), 32'd8);

        // Errored frame
        v0 = n_out; d0 = n_drop;
`ifdef EXT_FIFO_TX_DROP_ERR_EN
        send_frame(10, 8'hC0, 1'b1, OC_ERR);
        drain();
        chk("t5_drop_pulses", 32'(n_drop - d0), 32'd1);
        chk("t5_out", 32'(n_out - v0), 32'd0);
`else
        send_frame(10, 8'hC0, 1'b1, OC_COMMIT);
        drain();
        chk("t5_drop_pulses", 32'(n_drop - d0), 32'd0);
        chk("t5_out", 32'(n_out - v0), 32'd10);
`endif

        // Reset mid-frame with a committed frame pending
        m_if.tready = 1'b0;
        send_frame(3, 8'hE0, 1'b0, OC_COMMIT);
        for (int i = 0; i < 5; i++) beat(8'(8'h50 + 8'(i)), 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("t6_cnt_in_reset", 32'(pkt_count), 32'd0);
        chk("t6_tvalid_in_reset", 32'(m_if.tvalid), 32'd0);
        rstn = 1'b1;
        m_if.tready = 1'b1;
        v0 = n_out;
        send_frame(8, 8'h70, 1'b0, OC_COMMIT);
        drain();
        chk("t6_out", 32'(n_out - v0), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ext_fifo_tx_pkt_buf.md
# ext_fifo_tx_pkt_buf

Store-and-forward packet buffer on the GEM external-FIFO transmit path. It sits directly upstream of the external-FIFO TX stage. It accepts 8-bit AXI-Stream frames from the DMA/packet source and releases a frame downstream only once the whole frame is stored, so the MAC never sees a mid-frame underflow. Frames that overflow the buffer, or that exceed the packet-count limit, are discarded whole.

## Interface
Parameters:
- DEPTH, 2048, byte capacity; power of two, minimum 64
- MAX_PKTS, 16, maximum committed frames held; power of two

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  8  ingress byte
- s_axis_tvalid  in  1  ingress beat valid
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  frame error flag, sampled on the last beat
- s_axis_tready  out  1  ingress ready; constant 1 outside reset
- m_axis_tdata  out  8  egress byte, to TX stage axis_tdata
- m_axis_tvalid  out  1  egress beat valid
- m_axis_tlast  out  1  egress last byte
- m_axis_tuser  out  1  egress error flag, valid on the last beat
- m_axis_tready  in  1  egress ready, driven by the MAC read strobe
- pkt_count_o  out  $clog2(MAX_PKTS)+1  committed frames not yet fully sent
- overflow_o  out  1  one-cycle pulse: a frame was dropped for lack of space or packet slots
- drop_o  out  1  one-cycle pulse: a frame was dropped for tuser error (macro only)

## Operation
- Storage is a DEPTH-entry RAM. Each entry holds {tuser, tlast, tdata}.
- Pointers wr_ptr, commit_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
- Used space = wr_ptr − rd_ptr. The buffer is full when used space equals DEPTH.
- Ingress write:
  - Every beat with tvalid=1 is accepted.
  - If the buffer is not full and the frame is not yet marked overrun, the byte is written at wr_ptr and wr_ptr increments.
  - If the buffer is full, the byte is discarded and the frame is marked overrun.
- Frame end (tlast beat accepted):
  - Commit when the frame is not overrun, pkt_count < MAX_PKTS, and it is not an error drop. Commit sets commit_ptr ← wr_ptr+1 (this beat's write included) and increments pkt_count.
  - Otherwise roll back: wr_ptr ← commit_ptr, and pulse overflow_o (or drop_o for an error drop).
  - The overrun mark is cleared in either case.
- Egress uses a one-entry output register fed from RAM (one cycle of read latency).
  - A RAM read is issued when rd_ptr ≠ commit_ptr and the output register is empty or is being consumed this cycle.
  - Egress is never stalled by a bubble while data is available: back-to-back beats are sustained at one per cycle.
- Hand-off and counting:
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - A transfer with m_axis_tlast=1 decrements pkt_count.
  - Commit and last-beat transfer in the same cycle leave pkt_count unchanged.
- Boundary cases:
  - A frame of exactly DEPTH bytes into an empty buffer commits.
  - A frame of DEPTH+1 bytes is dropped.
  - A 1-byte frame is legal.
- Reset mid-operation: all pointers, the count and the output register clear. A partial ingress frame is lost. The first valid beat after reset starts a new frame.

## Timing
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0
  - pkt_count_o=0, overflow_o=0, drop_o=0
  - s_axis_tready rises the first cycle after rstn=1.
- Latency: m_axis_tvalid asserts exactly 2 cycles after the cycle that accepts the committing tlast, when the egress side is idle.
- m_axis_tdata, tlast and tuser hold stable while tvalid=1 and tready=0.
- overflow_o and drop_o pulse in the cycle after the tlast beat.
- pkt_count_o updates in the cycle after a commit or last-beat transfer.

## Configuration
- With EXT_FIFO_TX_DROP_ERR_EN defined:
  - A frame whose tlast beat carries tuser=1 is rolled back and drop_o pulses.
  - m_axis_tuser is tied 0.
- Without it:
  - Errored frames are committed normally and tuser is stored and forwarded on m_axis_tuser with the last byte.
  - drop_o is tied 0.

## Structure
- Shared package ext_fifo_pkg:
  - EXT_FIFO_DATA_W=8
  - RAM entry width constant (10)
  - Default DEPTH/MAX_PKTS constants
  - Pointer-width helper function
- One sub-module, ext_fifo_sdp_ram: simple dual-port RAM with one write port, one registered read port, a single clk, and no reset on the array.

## Test plan
- 64-byte frame, m_axis_tready=1 → no m_axis_tvalid before tlast is accepted; first byte 2 cycles later; 64 contiguous beats, tlast on byte 64; pkt_count 1→0.
- Three back-to-back 1-byte frames 0xA1, 0xA2, 0xA3 with m_axis_tready=0 → pkt_count=3; release tready → 3 beats, each with tlast=1, in order.
- DEPTH=64: 64-byte frame commits; a following 65-byte frame with egress stalled → overflow_o pulses once, pkt_count stays 1, egress delivers only the first frame.
- MAX_PKTS=4, five 2-byte frames with egress stalled → fifth dropped, overflow_o pulses, pkt_count=4.
- 10-byte frame with tuser=1 on tlast → macro defined: drop_o pulses, nothing egresses; macro undefined: 10 bytes egress, m_axis_tuser=1 on byte 10.
- rstn=0 for one cycle mid-frame after 5 of 20 bytes, then a fresh 8-byte frame → only the 8-byte frame egresses; pkt_count=0 during reset.
